// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use hazard
// detection and a divide-by-zero flag computed on the forwarded divisor.
module id_ex_stage #(
    parameter int FWD_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_alusrc,
    input  logic        id_uses_rt,
    input  logic [2:0]  id_alucon,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        exmem_regwrite,
    input  logic        memwb_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_data,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic [2:0]  ex_alucon,
    output logic [31:0] ex_data_a,
    output logic [31:0] ex_data_b,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd,
    output logic        load_use_hazard,
    output logic        ex_div_zero
);

    logic        valid_reg, regwrite_reg, memread_reg, alusrc_reg;
    logic [2:0]  alucon_reg;
    logic [31:0] rs_data_reg, rt_data_reg, imm_reg;
    logic [4:0]  rs_reg, rt_reg, rd_reg;

    logic        valid_next, regwrite_next, memread_next, alusrc_next;
    logic [2:0]  alucon_next;
    logic [31:0] rs_data_next, rt_data_next, imm_next;
    logic [4:0]  rs_next, rt_next, rd_next;

    logic             bubble;
    logic [1:0][4:0]  src_num;
    logic [1:0][31:0] src_data;
    logic [1:0][31:0] fwd_data;

    assign load_use_hazard = valid_reg & memread_reg & (rd_reg != 5'd0)
                           & ((rd_reg == id_rs) | (id_uses_rt & (rd_reg == id_rt)))
                           & id_valid;

    assign bubble = flush | load_use_hazard;

    // A bubble also zeroes alusrc/rs/rt so a squashed slot can never pick up
    // a forwarded value and all outputs read zero.
    always_comb begin
        valid_next    = valid_reg;
        regwrite_next = regwrite_reg;
        memread_next  = memread_reg;
        alusrc_next   = alusrc_reg;
        alucon_next   = alucon_reg;
        rs_data_next  = rs_data_reg;
        rt_data_next  = rt_data_reg;
        imm_next      = imm_reg;
        rs_next       = rs_reg;
        rt_next       = rt_reg;
        rd_next       = rd_reg;
        if (bubble) begin
            valid_next    = 1'b0;
            regwrite_next = 1'b0;
            memread_next  = 1'b0;
            alusrc_next   = 1'b0;
            alucon_next   = 3'b000;
            rs_data_next  = 32'd0;
            rt_data_next  = 32'd0;
            imm_next      = 32'd0;
            rs_next       = 5'd0;
            rt_next       = 5'd0;
            rd_next       = 5'd0;
        end else if (!stall) begin
            valid_next    = id_valid;
            regwrite_next = id_regwrite;
            memread_next  = id_memread;
            alusrc_next   = id_alusrc;
            alucon_next   = id_alucon;
            rs_data_next  = id_rs_data;
            rt_data_next  = id_rt_data;
            imm_next      = id_imm;
            rs_next       = id_rs;
            rt_next       = id_rt;
            rd_next       = id_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            memread_reg  <= 1'b0;
            alusrc_reg   <= 1'b0;
            alucon_reg   <= 3'b000;
            rs_data_reg  <= 32'd0;
            rt_data_reg  <= 32'd0;
            imm_reg      <= 32'd0;
            rs_reg       <= 5'd0;
            rt_reg       <= 5'd0;
            rd_reg       <= 5'd0;
        end else begin
            valid_reg    <= valid_next;
            regwrite_reg <= regwrite_next;
            memread_reg  <= memread_next;
            alusrc_reg   <= alusrc_next;
            alucon_reg   <= alucon_next;
            rs_data_reg  <= rs_data_next;
            rt_data_reg  <= rt_data_next;
            imm_reg      <= imm_next;
            rs_reg       <= rs_next;
            rt_reg       <= rt_next;
            rd_reg       <= rd_next;
        end
    end

    assign src_num[0]  = rs_reg;
    assign src_num[1]  = rt_reg;
    assign src_data[0] = rs_data_reg;
    assign src_data[1] = rt_data_reg;

    // Operand 0 is rs, operand 1 is rt; EX/MEM wins over MEM/WB, r0 never forwards.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_exmem, hit_memwb;
            assign hit_exmem = (FWD_EN != 0) && exmem_regwrite
                             && (exmem_rd != 5'd0) && (exmem_rd == src_num[gi]);
            assign hit_memwb = (FWD_EN != 0) && memwb_regwrite
                             && (memwb_rd != 5'd0) && (memwb_rd == src_num[gi]);
            assign fwd_data[gi] = hit_exmem ? exmem_result
                                : hit_memwb ? memwb_data
                                : src_data[gi];
        end
    endgenerate

    assign ex_valid      = valid_reg;
    assign ex_regwrite   = regwrite_reg;
    assign ex_memread    = memread_reg;
    assign ex_alucon     = alucon_reg;
    assign ex_rd         = rd_reg;
    assign ex_data_a     = fwd_data[0];
    assign ex_data_b     = alusrc_reg ? imm_reg : fwd_data[1];
    assign ex_store_data = fwd_data[1];
    assign ex_div_zero   = valid_reg & (alucon_reg == 3'b011) & (ex_data_b == 32'd0);

endmodule

// File: tb/tb_id_ex_stage.sv
// Random + directed bench for id_ex_stage: a behavioural model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid, id_regwrite, id_memread, id_alusrc, id_uses_rt;
    logic [2:0]  id_alucon;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_data;
    logic        ex_valid, ex_regwrite, ex_memread;
    logic [2:0]  ex_alucon;
    logic [31:0] ex_data_a, ex_data_b, ex_store_data;
    logic [4:0]  ex_rd;
    logic        load_use_hazard, ex_div_zero;

    id_ex_stage #(.FWD_EN(1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_alusrc(id_alusrc), .id_uses_rt(id_uses_rt), .id_alucon(id_alucon),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_data(memwb_data),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_alucon(ex_alucon), .ex_data_a(ex_data_a), .ex_data_b(ex_data_b),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .load_use_hazard(load_use_hazard), .ex_div_zero(ex_div_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v, rw, mr, as;
        logic [2:0]  ac;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
    } st_t;

    typedef struct packed {
        logic        v, rw, mr;
        logic [2:0]  ac;
        logic [31:0] a, b, sd;
        logic [4:0]  rd;
        logic        luh, dz;
    } out_t;

    int   tests = 0;
    int   fails = 0;
    int   txn   = 0;
    st_t  m;
    out_t exp_q[$];
    out_t mon_e, mon_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic set_idle();
        stall = 0; flush = 0;
        id_valid = 0; id_regwrite = 0; id_memread = 0; id_alusrc = 0; id_uses_rt = 0;
        id_alucon = 3'd0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        exmem_regwrite = 0; memwb_regwrite = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_result = 0; memwb_data = 0;
    endtask

    // Value an instruction in EX sees for source register r holding d.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] d);
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == r) return exmem_result;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == r) return memwb_data;
        return d;
    endfunction

    function automatic out_t predict();
        out_t        o;
        logic [31:0] rt_val;
        rt_val = operand(m.rt, m.rtd);
        o.v   = m.v;
        o.rw  = m.rw;
        o.mr  = m.mr;
        o.ac  = m.ac;
        o.rd  = m.rd;
        o.a   = operand(m.rs, m.rsd);
        o.sd  = rt_val;
        o.b   = m.as ? m.imm : rt_val;
        o.luh = id_valid && m.v && m.mr && m.rd != 0
                && (m.rd == id_rs || (id_uses_rt && m.rd == id_rt));
        o.dz  = m.v && m.ac == 3'd3 && o.b == 0;
        return o;
    endfunction

    // Predict this cycle's outputs, then advance the model across the edge.
    task automatic step();
        out_t e;
        e = predict();
        exp_q.push_back(e);
        if (flush || e.luh) m = '0;
        else if (!stall)
            m = '{id_valid, id_regwrite, id_memread, id_alusrc, id_alucon,
                  id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd};
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {ex_valid, ex_regwrite, ex_memread, ex_alucon, ex_data_a, ex_data_b,
                     ex_store_data, ex_rd, load_use_hazard, ex_div_zero};
            tests++;
            txn++;
            if (mon_a !== mon_e) begin
                fails++;
                $display("FAIL txn %0d: got v%0b rw%0b mr%0b ac%0d a=%h b=%h sd=%h rd=%0d luh=%0b dz=%0b, required v%0b rw%0b mr%0b ac%0d a=%h b=%h sd=%h rd=%0d luh=%0b dz=%0b",
                         txn, mon_a.v, mon_a.rw, mon_a.mr, mon_a.ac, mon_a.a, mon_a.b, mon_a.sd,
                         mon_a.rd, mon_a.luh, mon_a.dz, mon_e.v, mon_e.rw, mon_e.mr, mon_e.ac,
                         mon_e.a, mon_e.b, mon_e.sd, mon_e.rd, mon_e.luh, mon_e.dz);
            end else begin
                $display("[TB] txn %0d ok v=%0b a=%h b=%h rd=%0d luh=%0b dz=%0b",
                         txn, mon_a.v, mon_a.a, mon_a.b, mon_a.rd, mon_a.luh, mon_a.dz);
            end
        end
    end

    initial begin
        set_idle();
        reset = 1;
        m = '0;
        @(posedge clk);
        #1;
        check("reset_valid", 32'(ex_valid), 0);
        check("reset_regwrite", 32'(ex_regwrite), 0);
        check("reset_alucon", 32'(ex_alucon), 0);
        check("reset_data_a", ex_data_a, 0);
        check("reset_data_b", ex_data_b, 0);
        check("reset_store", ex_store_data, 0);
        check("reset_rd", 32'(ex_rd), 0);
        check("reset_luh_dz", 32'({load_use_hazard, ex_div_zero}), 0);
        reset = 0;

        // Basic capture with one-cycle latency
        id_valid = 1; id_regwrite = 1; id_rs = 1; id_rt = 2; id_rd = 3;
        id_rs_data = 5; id_rt_data = 7;
        step();
        set_idle(); #1;
        check("cap_a", ex_data_a, 5);
        check("cap_b", ex_data_b, 7);
        check("cap_valid", 32'(ex_valid), 1);

        // Forwarding priority on rs
        id_valid = 1; id_regwrite = 1; id_rs = 3; id_rs_data = 32'h55; id_rt = 2;
        id_rt_data = 32'h77; id_rd = 6;
        step();
        set_idle();
        exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_rd = 3; memwb_data = 32'h22;
        #1;
        check("fwd_exmem", ex_data_a, 32'h11);
        exmem_regwrite = 0; #1;
        check("fwd_memwb", ex_data_a, 32'h22);
        memwb_regwrite = 0; #1;
        check("fwd_none", ex_data_a, 32'h55);
        exmem_regwrite = 1; exmem_rd = 2; #1;
        check("fwd_b_exmem", ex_data_b, 32'h11);
        check("fwd_store_exmem", ex_store_data, 32'h11);
        set_idle();
        id_valid = 1; id_rs = 0; id_rs_data = 32'h66;
        step();
        set_idle();
        exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_rd = 0; memwb_data = 32'h22;
        #1;
        check("fwd_r0", ex_data_a, 32'h66);

        // Load-use hazard
        set_idle();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd = 4;
        step();
        set_idle();
        id_valid = 1; id_rs = 4; id_regwrite = 1; id_rd = 5;
        #1;
        check("luh_set", 32'(load_use_hazard), 1);
        step();
        set_idle(); #1;
        check("luh_bubble_valid", 32'(ex_valid), 0);
        check("luh_bubble_rw", 32'(ex_regwrite), 0);

        // Stall holds, flush overrides stall
        id_valid = 1; id_regwrite = 1; id_rd = 7; id_rs_data = 32'h123;
        step();
        set_idle();
        stall = 1; id_valid = 1; id_rd = 9; id_rs_data = 32'h999;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_a", ex_data_a, 32'h123);
            check("stall_rd", 32'(ex_rd), 7);
        end
        flush = 1;
        step();
        check("flush_valid", 32'(ex_valid), 0);
        check("flush_rd", 32'(ex_rd), 0);
        check("flush_a", ex_data_a, 0);

        // Divide by zero on immediate divisor
        set_idle();
        id_valid = 1; id_alucon = 3'b011; id_alusrc = 1; id_imm = 0; id_rt_data = 5;
        step();
        set_idle(); #1;
        check("divz_imm0", 32'(ex_div_zero), 1);
        id_valid = 1; id_alucon = 3'b011; id_alusrc = 1; id_imm = 2;
        step();
        set_idle(); #1;
        check("divz_imm2", 32'(ex_div_zero), 0);

        // Asynchronous reset between edges while stalled
        id_valid = 1; id_regwrite = 1; id_rd = 9; id_rs_data = 32'hABCD; id_rt_data = 32'h1234;
        step();
        set_idle();
        stall = 1;
        #2;
        reset = 1;
        #1;
        check("areset_valid", 32'(ex_valid), 0);
        check("areset_regwrite", 32'(ex_regwrite), 0);
        check("areset_a", ex_data_a, 0);
        check("areset_b", ex_data_b, 0);
        check("areset_store", ex_store_data, 0);
        check("areset_rd", 32'(ex_rd), 0);
        m = '0;
        @(posedge clk);
        #1;
        reset = 0;
        set_idle();
        id_valid = 1; id_rs_data = 32'h42;
        step();
        set_idle(); #1;
        check("post_reset_valid", 32'(ex_valid), 1);
        check("post_reset_a", ex_data_a, 32'h42);

        // Randomized traffic with small register numbers to provoke forwarding/hazards
        for (int n = 0; n < 500; n++) begin
            stall          = ($urandom_range(0, 4) == 0);
            flush          = ($urandom_range(0, 9) == 0);
            id_valid       = ($urandom_range(0, 3) != 0);
            id_regwrite    = 1'($urandom_range(0, 1));
            id_memread     = ($urandom_range(0, 2) == 0);
            id_alusrc      = 1'($urandom_range(0, 1));
            id_uses_rt     = 1'($urandom_range(0, 1));
            id_alucon      = 3'($urandom_range(0, 4));
            id_rs_data     = $urandom;
            id_rt_data     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            id_imm         = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            id_rs          = 5'($urandom_range(0, 4));
            id_rt          = 5'($urandom_range(0, 4));
            id_rd          = 5'($urandom_range(0, 4));
            exmem_regwrite = 1'($urandom_range(0, 1));
            memwb_regwrite = 1'($urandom_range(0, 1));
            exmem_rd       = 5'($urandom_range(0, 4));
            memwb_rd       = 5'($urandom_range(0, 4));
            exmem_result   = $urandom;
            memwb_data     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            step();
        end

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
